// File: rtl/multiplexor.sv
// Butterfly pair re-serialiser: buffers result pairs in a small FIFO
// and emits one complex sample per cycle over a valid/ready handshake.
module multiplexor #(
  parameter int  bit_width  = 16,
  parameter int  fifo_depth = 4,
  localparam int addr_width = $clog2(fifo_depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [bit_width-1:0] Re_i1,
  input  logic [bit_width-1:0] Im_i1,
  input  logic [bit_width-1:0] Re_i2,
  input  logic [bit_width-1:0] Im_i2,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [bit_width-1:0] Re_o,
  output logic [bit_width-1:0] Im_o,
  output logic                 out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [addr_width:0]  fill_level
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  localparam int pw = 4 * bit_width;
  localparam logic [addr_width:0] full_lvl =
    (addr_width + 1)'(fifo_depth);

  logic [pw-1:0]         mem [fifo_depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [1:0]            state;
  logic [bit_width-1:0]  hold_re;
  logic [bit_width-1:0]  hold_im;
  logic [pw-1:0]         head;
  logic [bit_width-1:0]  head_re1;
  logic [bit_width-1:0]  head_im1;
  logic [bit_width-1:0]  head_re2;
  logic [bit_width-1:0]  head_im2;
  logic                  push;
  logic                  pop;
  logic                  has_data;
  logic [addr_width:0]   fill_nxt;

  assign in_ready = !rst && (fill_level != full_lvl);
  assign push     = in_valid && in_ready;
  assign has_data = (fill_level != '0);

  assign head     = mem[rd_ptr];
  assign head_re1 = head[pw-1 -: bit_width];
  assign head_im1 = head[3*bit_width-1 -: bit_width];
  assign head_re2 = head[2*bit_width-1 -: bit_width];
  assign head_im2 = head[bit_width-1:0];

  // Pops only happen when the output stage takes a new head pair.
  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      (state == IDLE):   pop = has_data;
      (state == SECOND): pop = out_ready && has_data;
      default:           pop = 1'b0;
    endcase
  end

  always_comb begin
    fill_nxt = fill_level;
    if (push && !pop)
      fill_nxt = fill_level + 1'b1;
    else if (pop && !push)
      fill_nxt = fill_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {Re_i1, Im_i1, Re_i2, Im_i2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_sel    <= 1'b0;
      Re_o       <= '0;
      Im_o       <= '0;
      hold_re    <= '0;
      hold_im    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fill_level <= fill_nxt;

      unique case (1'b1)
        (state == IDLE): begin
          if (has_data) begin
            Re_o      <= head_re1;
            Im_o      <= head_im1;
            hold_re   <= head_re2;
            hold_im   <= head_im2;
            out_sel   <= 1'b0;
            out_valid <= 1'b1;
            state     <= FIRST;
          end else begin
            out_valid <= 1'b0;
          end
        end
        (state == FIRST): begin
          if (out_ready) begin
            Re_o    <= hold_re;
            Im_o    <= hold_im;
            out_sel <= 1'b1;
            state   <= SECOND;
          end
        end
        (state == SECOND): begin
          if (out_ready) begin
            if (has_data) begin
              Re_o      <= head_re1;
              Im_o      <= head_im1;
              hold_re   <= head_re2;
              hold_im   <= head_im2;
              out_sel   <= 1'b0;
              out_valid <= 1'b1;
              state     <= FIRST;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplexor.sv
// Directed bench for multiplexor with a sample scoreboard
// checked at every output handshake.
module tb_multiplexor;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sel;
  } samp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Re_i1, Im_i1, Re_i2, Im_i2;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Re_o, Im_o;
  logic        out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill_level;

  int checks   = 0;
  int failures = 0;

  samp_t       sb[$];
  samp_t       e;
  bit          held = 0;
  logic [15:0] h_re, h_im;
  logic        h_sel;

  multiplexor #(.bit_width(16), .fifo_depth(4)) dut (
    .clk(clk), .rst(rst),
    .Re_i1(Re_i1), .Im_i1(Im_i1),
    .Re_i2(Re_i2), .Im_i2(Im_i2),
    .in_valid(in_valid), .in_ready(in_ready),
    .Re_o(Re_o), .Im_o(Im_o),
    .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [15:0] a, b, c, d,
                            input bit acc, input string tag);
    Re_i1 = a; Im_i1 = b; Re_i2 = c; Im_i2 = d;
    in_valid = 1'b1;
    @(negedge clk);
    chk(tag, in_ready, acc);
    if (acc) begin
      sb.push_back('{a, b, 1'b0});
      sb.push_back('{c, d, 1'b1});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle"}, out_valid, 1'b0);
    step();
  endtask

  // Scoreboard and stall-stability monitor
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held && out_valid) begin
        checks++;
        assert (Re_o === h_re && Im_o === h_im && out_sel === h_sel)
        else begin
          failures++;
          $error("FAIL stall_hold observed=%h/%h/%b expected=%h/%h/%b",
                 Re_o, Im_o, out_sel, h_re, h_im, h_sel);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL extra_sample observed=%h/%h expected=none",
                 Re_o, Im_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (Re_o === e.re && Im_o === e.im && out_sel === e.sel)
          else begin
            failures++;
            $error("FAIL sample observed=%h/%h/%b expected=%h/%h/%b",
                   Re_o, Im_o, out_sel, e.re, e.im, e.sel);
          end
        end
      end
      held  = out_valid && !out_ready;
      h_re  = Re_o;
      h_im  = Im_o;
      h_sel = out_sel;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0;
    step(); step();
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_fill", fill_level, 0);
    chk("rst_re", Re_o, 0);
    chk("rst_sel", out_sel, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    step();

    // single pair latency
    out_ready = 1'b1;
    drive_pair(16'd1, 16'd2, 16'd3, 16'd4, 1, "t1_ready");
    @(negedge clk);
    chk("t1_lat_valid", out_valid, 1'b0);
    chk("t1_lat_fill", fill_level, 1);
    step();
    @(negedge clk);
    chk("t1_first_valid", out_valid, 1'b1);
    chk("t1_first_re", Re_o, 1);
    chk("t1_first_sel", out_sel, 1'b0);
    step();
    @(negedge clk);
    chk("t1_second_re", Re_o, 3);
    chk("t1_second_im", Im_o, 4);
    chk("t1_second_sel", out_sel, 1'b1);
    step();
    @(negedge clk);
    chk("t1_end_valid", out_valid, 1'b0);
    step();

    // fill to full with the consumer stalled
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Re_i1 = 16'h100 + 16'(4*k); Im_i1 = 16'h101 + 16'(4*k);
      Re_i2 = 16'h102 + 16'(4*k); Im_i2 = 16'h103 + 16'(4*k);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t2_ready", in_ready, 1'b1);
      chk("t2_fill", fill_level, (k == 0) ? 0 : (k == 1) ? 1 : k - 1);
      sb.push_back('{Re_i1, Im_i1, 1'b0});
      sb.push_back('{Re_i2, Im_i2, 1'b1});
      step();
    end
    Re_i1 = 16'hdead; Im_i1 = 16'hbeef; Re_i2 = 16'h0bad; Im_i2 = 16'hf00d;
    @(negedge clk);
    chk("t2_full_fill", fill_level, 4);
    chk("t2_full_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_drop_fill", fill_level, 4);
    step();
    out_ready = 1'b1;
    drain("t2_drain");

    // toggled ready while streaming
    out_ready = 1'b0;
    drive_pair(16'd10, 16'd11, 16'd12, 16'd13, 1, "t3_ready_a");
    drive_pair(16'd20, 16'd21, 16'd22, 16'd23, 1, "t3_ready_b");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain("t3_drain");

    // half-rate streaming with pointer wrap
    for (int p = 0; p < 8; p++) begin
      Re_i1 = 16'h40 + 16'(4*p); Im_i1 = 16'h41 + 16'(4*p);
      Re_i2 = 16'h42 + 16'(4*p); Im_i2 = 16'h43 + 16'(4*p);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t4_ready", in_ready, 1'b1);
      chk("t4_fill_le1", fill_level <= 3'd1, 1'b1);
      if (p > 0) chk("t4_cont_a", out_valid, 1'b1);
      sb.push_back('{Re_i1, Im_i1, 1'b0});
      sb.push_back('{Re_i2, Im_i2, 1'b1});
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_fill_le1b", fill_level <= 3'd1, 1'b1);
      if (p > 0) chk("t4_cont_b", out_valid, 1'b1);
      step();
    end
    drain("t4_drain");

    // reset mid-stream in SECOND with three pairs queued
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      drive_pair(16'h200 + 16'(k), 16'h210 + 16'(k),
                 16'h220 + 16'(k), 16'h230 + 16'(k), 1, "t5_ready");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_pre_fill", fill_level, 3);
    chk("t5_pre_sel", out_sel, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_fill", fill_level, 0);
    chk("t5_re", Re_o, 0);
    step();
    out_ready = 1'b1;
    drive_pair(16'd7, 16'd8, 16'd9, 16'hfff7, 1, "t5_new_ready");
    drain("t5_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
